// File: rtl/paddle_frame_renderer_if.sv
// Display-side signal bundle between the frame renderer and its neighbours:
// the paddle position coming from the game logic, and the VGA timing, colour
// and pixel-coordinate outputs going to the connector.
interface paddle_frame_renderer_if;
  logic [9:0] paddle_x_pixel;
  logic       start_update;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       active;

  // Renderer side: consumes the paddle position, produces video.
  modport master (
    input  paddle_x_pixel,
    output start_update, hsync, vsync, red, green, blue, pixel_x, pixel_y, active
  );

  // Game logic / connector side.
  modport slave (
    output paddle_x_pixel,
    input  start_update, hsync, vsync, red, green, blue, pixel_x, pixel_y, active
  );
endinterface

// File: rtl/paddle_frame_renderer.sv
// VGA frame renderer: free-running raster counters, sync generation, a
// once-per-frame game update pulse, a per-frame paddle latch, and a 3-3-2 RGB
// pixel stream showing paddle, walls and background. All outputs are
// registered and describe the raster position of the previous cycle.
module paddle_frame_renderer #(
  parameter int unsigned H_ACTIVE            = 800,
  parameter int unsigned H_FRONT             = 40,
  parameter int unsigned H_SYNC              = 128,
  parameter int unsigned H_BACK              = 88,
  parameter int unsigned V_ACTIVE            = 600,
  parameter int unsigned V_FRONT             = 1,
  parameter int unsigned V_SYNC              = 4,
  parameter int unsigned V_BACK              = 23,
  parameter logic [9:0]  PADDLE_LENGTH_PIXEL = 10'd60,
  parameter logic [9:0]  PADDLE_Y_PIXEL      = 10'd570,
  parameter logic [9:0]  PADDLE_HEIGHT_PIXEL = 10'd8,
  parameter logic [9:0]  WALL_PIXEL          = 10'd8,
  parameter logic [9:0]  RESET_PADDLE_X      = 10'd370,
  parameter logic [7:0]  PADDLE_COLOR        = 8'hFF,
  parameter logic [7:0]  WALL_COLOR          = 8'h92,
  parameter logic [7:0]  BG_COLOR            = 8'h00
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  paddle_frame_renderer_if.master   vga
);

  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] WALL_L   = {1'b0, WALL_PIXEL};
  localparam logic [10:0] WALL_R   = 11'(H_ACTIVE) - {1'b0, WALL_PIXEL};
  localparam logic [9:0]  PAD_YEND = PADDLE_Y_PIXEL + PADDLE_HEIGHT_PIXEL;

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [9:0]  paddle_x_q, paddle_x_d;

  logic        start_update_q, start_update_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic [7:0]  rgb_q, rgb_d;
  logic [9:0]  pixel_x_q, pixel_x_d;
  logic [9:0]  pixel_y_q, pixel_y_d;

  logic [10:0] paddle_right;
  logic        paddle_hit;
  logic        wall_hit;

  // Raster advance and paddle latch at the very last position of the frame.
  always_comb begin
    h_d        = h_q + 11'd1;
    v_d        = v_q;
    paddle_x_d = paddle_x_q;
    if (h_q == H_LAST) begin
      h_d = 11'd0;
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      if (v_q == V_LAST) begin
        paddle_x_d = vga.paddle_x_pixel;
      end
    end
  end

  // Registered output values derived from the current raster position.
  always_comb begin
    // Right edge summed in 11 bits so a paddle near x=1023 cannot wrap.
    paddle_right   = {1'b0, paddle_x_q} + {1'b0, PADDLE_LENGTH_PIXEL};
    paddle_hit     = (h_q >= {1'b0, paddle_x_q}) && (h_q < paddle_right) &&
                     (v_q >= PADDLE_Y_PIXEL) && (v_q < PAD_YEND);
    wall_hit       = (h_q < WALL_L) || (h_q >= WALL_R) || (v_q < WALL_PIXEL);
    active_d       = (h_q < H_ACT) && (v_q < V_ACT);
    hsync_d        = (h_q >= HS_START) && (h_q < HS_END);
    vsync_d        = (v_q >= VS_START) && (v_q < VS_END);
    start_update_d = (h_q == 11'd0) && (v_q == V_ACT);
    pixel_x_d      = h_q[9:0];
    pixel_y_d      = v_q;
    rgb_d          = 8'h00;
    if (active_d) begin
      if (paddle_hit)    rgb_d = PADDLE_COLOR;
      else if (wall_hit) rgb_d = WALL_COLOR;
      else               rgb_d = BG_COLOR;
    end
  end

  // Raster counters and latched paddle position.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q        <= 11'd0;
      v_q        <= 10'd0;
      paddle_x_q <= RESET_PADDLE_X;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      paddle_x_q <= paddle_x_d;
    end
  end

  // Output registers, cleared by reset so a mid-frame reset aborts any pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_update_q <= 1'b0;
      hsync_q        <= 1'b0;
      vsync_q        <= 1'b0;
      active_q       <= 1'b0;
      rgb_q          <= 8'h00;
      pixel_x_q      <= 10'd0;
      pixel_y_q      <= 10'd0;
    end else begin
      start_update_q <= start_update_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      active_q       <= active_d;
      rgb_q          <= rgb_d;
      pixel_x_q      <= pixel_x_d;
      pixel_y_q      <= pixel_y_d;
    end
  end

  assign vga.start_update = start_update_q;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.active       = active_q;
  assign vga.red          = rgb_q[7:5];
  assign vga.green        = rgb_q[4:2];
  assign vga.blue         = rgb_q[1:0];
  assign vga.pixel_x      = pixel_x_q;
  assign vga.pixel_y      = pixel_y_q;

endmodule

// File: tb/tb_paddle_frame_renderer.sv
// Self-checking bench for paddle_frame_renderer. The raster is shrunk through
// the timing parameters so that several whole frames fit in a short run; the
// reference model derives every output from the cycle index with plain
// division/modulo and the frame-rule description of sync, pulse and colour.
module tb_paddle_frame_renderer;

  localparam int HA = 160, HF = 8,  HS = 24, HB = 16;
  localparam int VA = 40,  VF = 1,  VS = 4,  VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 208
  localparam int VT = VA + VF + VS + VB;   // 48
  localparam int FR = HT * VT;             // cycles per frame
  localparam int PL = 60, PY = 30, PH = 8, WL = 8, RST_PAD = 70;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  paddle_frame_renderer_if vif();

  paddle_frame_renderer #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PADDLE_LENGTH_PIXEL(10'(PL)), .PADDLE_Y_PIXEL(10'(PY)),
    .PADDLE_HEIGHT_PIXEL(10'(PH)), .WALL_PIXEL(10'(WL)),
    .RESET_PADDLE_X(10'(RST_PAD)),
    .PADDLE_COLOR(8'hFF), .WALL_COLOR(8'h92), .BG_COLOR(8'h00)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .vga  (vif)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  longint n_cyc = 0;     // cycles since reset release
  int    model_pad = RST_PAD;
  int    pad_in = 0;
  longint last_su = -1;
  bit    rnd_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: observed 0x%0h, expected 0x%0h", tag, n_cyc, obs, exp);
    end
  endtask

  // {start_update, hsync, vsync, active, rgb[7:0], pixel_x, pixel_y}
  function automatic logic [31:0] model_vec(int h, int v, int pad);
    bit su, hs, vs, act, pad_hit, wall;
    logic [7:0] rgb;
    logic [9:0] px, py;
    act     = (h < HA) && (v < VA);
    hs      = (h >= HA + HF) && (h < HA + HF + HS);
    vs      = (v >= VA + VF) && (v < VA + VF + VS);
    su      = (h == 0) && (v == VA);
    pad_hit = (h >= pad) && (h < pad + PL) && (v >= PY) && (v < PY + PH);
    wall    = (h < WL) || (h >= HA - WL) || (v < WL);
    rgb     = !act ? 8'h00 : pad_hit ? 8'hFF : wall ? 8'h92 : 8'h00;
    px      = act ? 10'(h) : 10'd0;
    py      = act ? 10'(v) : 10'd0;
    return {su, hs, vs, act, rgb, px, py};
  endfunction

  function automatic logic [31:0] dut_vec(bit mask);
    logic [9:0] px, py;
    px = (mask && !vif.active) ? 10'd0 : vif.pixel_x;
    py = (mask && !vif.active) ? 10'd0 : vif.pixel_y;
    return {vif.start_update, vif.hsync, vif.vsync, vif.active,
            vif.red, vif.green, vif.blue, px, py};
  endfunction

  function automatic logic [31:0] rgb_now();
    return {24'd0, vif.red, vif.green, vif.blue};
  endfunction

  // Hand-derived pixel expectations at known places in known frames.
  task automatic spot(int frame, int h, int v);
    if (frame == 0 && h == RST_PAD && v == PY)      check("reset_paddle_pos", rgb_now(), 32'hFF);
    if (frame == 1 && h == 100 && v == PY)          check("pad_left_edge", rgb_now(), 32'hFF);
    if (frame == 1 && h == 159 && v == PY)          check("pad_over_rwall", rgb_now(), 32'hFF);
    if (frame == 1 && h == 99 && v == PY)           check("pad_left_out", rgb_now(), 32'h00);
    if (frame == 1 && h == 100 && v == PY - 1)      check("row_above_pad", rgb_now(), 32'h00);
    if (frame == 1 && h == 3 && v == 20)            check("left_wall", rgb_now(), 32'h92);
    if (frame == 1 && h == 155 && v == 20)          check("right_wall", rgb_now(), 32'h92);
    if (frame == 1 && h == 50 && v == 5)            check("top_wall", rgb_now(), 32'h92);
    if (frame == 1 && h == 50 && v == 20)           check("background", rgb_now(), 32'h00);
    if (frame == 1 && h == 170 && v == 20)          check("blank_rgb", rgb_now(), 32'h00);
    if (frame == 2 && h == 100 && v == PY)          check("latch_hold_old", rgb_now(), 32'hFF);
    if (frame == 2 && h == 130 && v == PY + PH)     check("latch_hold_below", rgb_now(), 32'h00);
    if (frame == 3 && h == 130 && v == PY)          check("latch_new", rgb_now(), 32'hFF);
    if (frame == 3 && h == 129 && v == PY)          check("latch_new_left", rgb_now(), 32'h00);
    if (frame == 5 && h == 159 && v == PY + PH - 1) check("clip_edge", rgb_now(), 32'hFF);
    if (frame == 5 && h == 160 && v == PY)          check("clip_blank", rgb_now(), 32'h00);
  endtask

  // One clock with reset low: compare against the model, then update the latch model.
  task automatic step();
    int h, v, frame;
    @(posedge clk);
    #1;
    h     = int'(n_cyc % HT);
    v     = int'((n_cyc / HT) % VT);
    frame = int'(n_cyc / FR);
    check("raster", dut_vec(1'b1), model_vec(h, v, model_pad));
    spot(frame, h, v);
    if (vif.start_update) begin
      if (last_su < 0) check("su_first", 32'(n_cyc), 32'(VA * HT));
      else             check("su_period", 32'(n_cyc - last_su), 32'(FR));
      last_su = n_cyc;
    end
    if (h == HT - 1 && v == VT - 1) model_pad = pad_in;
    n_cyc++;
    if (rnd_mode && $urandom_range(0, 399) == 0) begin
      case ($urandom_range(0, 3))
        0:       pad_in = 0;
        1:       pad_in = HA - 1;
        2:       pad_in = int'($urandom_range(HA - PL, HA));
        default: pad_in = int'($urandom_range(0, 1023));
      endcase
    end
    vif.paddle_x_pixel = 10'(pad_in);
  endtask

  task automatic run_to(longint target);
    while (n_cyc < target && n_bad <= 20) step();
  endtask

  task automatic do_reset(int k);
    rst = 1'b1;
    repeat (k) begin
      @(posedge clk);
      #1;
      check("reset_outputs", dut_vec(1'b0), 32'd0);
    end
    rst       = 1'b0;
    n_cyc     = 0;
    model_pad = RST_PAD;
    last_su   = -1;
  endtask

  initial begin
    pad_in = 100;
    vif.paddle_x_pixel = 10'(pad_in);
    do_reset(3);
    // Frame 1 draws at 100; change mid frame 2 must not show until frame 3.
    run_to(2 * FR + 20 * HT);
    pad_in = 130;
    vif.paddle_x_pixel = 10'(pad_in);
    run_to(4 * FR);
    rnd_mode = 1;
    run_to(5 * FR - 100);
    rnd_mode = 0;
    pad_in = 140;
    vif.paddle_x_pixel = 10'(pad_in);
    // Reset during the last visible line of frame 5.
    run_to(5 * FR + (VA - 1) * HT + 50);
    if (n_bad <= 20) do_reset(5);
    pad_in = 0;
    vif.paddle_x_pixel = 10'(pad_in);
    run_to(VA * HT + HT);
    check("su_seen_after_reset", 32'(last_su), 32'(VA * HT));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
